// File: rtl/fltadd_seq.sv
// Sequential half-precision-style float adder that owns the data-memory port while busy.
// Define FLTADD_RNE_EN for round-to-nearest-even; otherwise the sum is truncated.
module fltadd_seq #(
  parameter logic [7:0] SRC_ADDR = 8'd128,
  parameter logic [7:0] DST_ADDR = 8'd132
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] DataAddress,
  output logic       ReadMem,
  output logic       WriteMem,
  output logic [7:0] DataIn,
  input  logic [7:0] DataOut
);

`ifdef FLTADD_RNE_EN
  localparam logic RNE_ON = 1'b1;
`else
  localparam logic RNE_ON = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_LD0, S_LD1, S_LD2, S_LD3, S_ALIGN, S_ADD, S_RND, S_WR0, S_WR1, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [7:0]  a0, a1, b0;
  logic [10:0] sig_l, sig_s, sig_r;
  logic [5:0]  exp_r;
  logic [3:0]  k_r;
  logic        rnd_r, stk_r, sign_r, err_r;

  // Returns {exp, significand}; handles rounding carry, overflow to infinity and zero.
  function automatic logic [16:0] round_norm(input logic [10:0] sig, input logic [5:0] exp_in,
                                             input logic rnd, input logic stk, input logic rne);
    logic        inc;
    logic [11:0] s;
    logic [5:0]  e;
    inc = rne & rnd & (stk | sig[0]);
    s   = {1'b0, sig} + {11'd0, inc};
    e   = exp_in;
    if (s[11]) begin
      s = s >> 1;
      e = e + 6'd1;
    end
    if (sig == 11'd0) begin
      e = 6'd0;
      s = 12'd0;
    end else if (e >= 6'd31) begin
      e = 6'd31;
      s = 12'd0;
    end
    return {e, s[10:0]};
  endfunction

  // Operand decode; B's low byte is taken straight off the bus during LD3.
  logic [4:0]         exp_a, exp_b;
  logic [10:0]        sig_a, sig_b;
  logic signed [6:0]  exp_diff;
  logic [6:0]         exp_mag;
  logic [3:0]         k_val;
  logic               a_larger, sign_mis;
  logic [11:0]        sum;
  logic [16:0]        rounded;

  always_comb begin
    exp_a    = a0[6:2];
    exp_b    = b0[6:2];
    sig_a    = (exp_a == 5'd0) ? 11'd0 : {1'b1, a0[1:0], a1};
    sig_b    = (exp_b == 5'd0) ? 11'd0 : {1'b1, b0[1:0], DataOut};
    exp_diff = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b});
    a_larger = ~exp_diff[6];
    exp_mag  = exp_diff[6] ? 7'(-exp_diff) : 7'(exp_diff);
    k_val    = (exp_mag > 7'd12) ? 4'd12 : exp_mag[3:0];
    sign_mis = a0[7] ^ b0[7];
    sum      = {1'b0, sig_l} + {1'b0, sig_s};
    rounded  = round_norm(sig_r, exp_r, rnd_r, stk_r, RNE_ON);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      a0     <= 8'd0;
      a1     <= 8'd0;
      b0     <= 8'd0;
      sig_l  <= 11'd0;
      sig_s  <= 11'd0;
      sig_r  <= 11'd0;
      exp_r  <= 6'd0;
      k_r    <= 4'd0;
      rnd_r  <= 1'b0;
      stk_r  <= 1'b0;
      sign_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE, S_DONE: if (start) err_r <= 1'b0;
        S_LD0: a0 <= DataOut;
        S_LD1: a1 <= DataOut;
        S_LD2: b0 <= DataOut;
        S_LD3: begin
          rnd_r <= 1'b0;
          stk_r <= 1'b0;
          k_r   <= k_val;
          if (sign_mis) begin
            err_r  <= 1'b1;
            sign_r <= 1'b0;
            exp_r  <= 6'd0;
            sig_r  <= 11'd0;
          end else begin
            sign_r <= a0[7];
            exp_r  <= {1'b0, a_larger ? exp_a : exp_b};
            sig_l  <= a_larger ? sig_a : sig_b;
            sig_s  <= a_larger ? sig_b : sig_a;
          end
        end
        S_ALIGN: begin
          sig_s <= sig_s >> 1;
          rnd_r <= sig_s[0];
          stk_r <= stk_r | rnd_r;
          k_r   <= k_r - 4'd1;
        end
        S_ADD: begin
          if (sum[11]) begin
            sig_r <= sum[11:1];
            rnd_r <= sum[0];
            stk_r <= stk_r | rnd_r;
            exp_r <= exp_r + 6'd1;
          end else begin
            sig_r <= sum[10:0];
          end
        end
        S_RND: begin
          exp_r <= rounded[16:11];
          sig_r <= rounded[10:0];
          if (sig_r == 11'd0) sign_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt   = state;
    busy        = 1'b0;
    done        = 1'b0;
    err         = err_r;
    DataAddress = 8'd0;
    ReadMem     = 1'b0;
    WriteMem    = 1'b0;
    DataIn      = 8'd0;
    case (state)
      S_IDLE: if (start) state_nxt = S_LD0;
      S_LD0: begin
        busy = 1'b1; ReadMem = 1'b1; DataAddress = SRC_ADDR;
        state_nxt = S_LD1;
      end
      S_LD1: begin
        busy = 1'b1; ReadMem = 1'b1; DataAddress = 8'(SRC_ADDR + 8'd1);
        state_nxt = S_LD2;
      end
      S_LD2: begin
        busy = 1'b1; ReadMem = 1'b1; DataAddress = 8'(SRC_ADDR + 8'd2);
        state_nxt = S_LD3;
      end
      S_LD3: begin
        busy = 1'b1; ReadMem = 1'b1; DataAddress = 8'(SRC_ADDR + 8'd3);
        if (sign_mis)            state_nxt = S_WR0;
        else if (k_val != 4'd0)  state_nxt = S_ALIGN;
        else                     state_nxt = S_ADD;
      end
      S_ALIGN: begin
        busy = 1'b1;
        if (k_r == 4'd1) state_nxt = S_ADD;
      end
      S_ADD: begin
        busy = 1'b1;
        state_nxt = S_RND;
      end
      S_RND: begin
        busy = 1'b1;
        state_nxt = S_WR0;
      end
      S_WR0: begin
        busy = 1'b1; WriteMem = 1'b1; DataAddress = DST_ADDR;
        DataIn = {sign_r, exp_r[4:0], sig_r[9:8]};
        state_nxt = S_WR1;
      end
      S_WR1: begin
        busy = 1'b1; WriteMem = 1'b1; DataAddress = 8'(DST_ADDR + 8'd1);
        DataIn = sig_r[7:0];
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_nxt = S_LD0;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fltadd_seq.sv
// Directed bench for fltadd_seq with a behavioural single-port byte memory.
module tb_fltadd_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, err, read_mem, write_mem;
  logic [7:0] data_address, data_in, data_out;

  logic [7:0]  mem [256];
  logic        ld_en = 1'b0;
  logic [15:0] ld_a = 16'd0, ld_b = 16'd0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fltadd_seq #(.SRC_ADDR(8'd128), .DST_ADDR(8'd132)) dut (
    .clk(clk), .reset(rst_n), .start(start), .busy(busy), .done(done), .err(err),
    .DataAddress(data_address), .ReadMem(read_mem), .WriteMem(write_mem),
    .DataIn(data_in), .DataOut(data_out)
  );

  assign data_out = mem[data_address];

  always @(posedge clk) begin
    if (ld_en) begin
      mem[128] <= ld_a[15:8];
      mem[129] <= ld_a[7:0];
      mem[130] <= ld_b[15:8];
      mem[131] <= ld_b[7:0];
      mem[132] <= 8'hEE;
      mem[133] <= 8'hEE;
    end else if (write_mem) begin
      mem[data_address] <= data_in;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    ld_a = a; ld_b = b; ld_en = 1'b1;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] res, input int lat, input logic e);
    int n;
    bit seen, proto_bad;
    preload(a, b);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({tag, " accept busy"}, {31'd0, busy}, 32'd1);
    check({tag, " accept err"}, {31'd0, err}, 32'd0);
    n = 0; seen = 0; proto_bad = 0;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1 n++;
      if (busy && done) proto_bad = 1;
      if (done) seen = 1;
      else if (!busy) proto_bad = 1;
    end
    if (read_mem || write_mem) proto_bad = 1;
    check({tag, " latency"}, n, lat);
    check({tag, " result"}, {16'd0, mem[132], mem[133]}, {16'd0, res});
    check({tag, " err"}, {31'd0, err}, {31'd0, e});
    check({tag, " protocol"}, {31'd0, proto_bad}, 32'd0);
  endtask

  initial begin
    logic [15:0] tie_exp;
`ifdef FLTADD_RNE_EN
    tie_exp = 16'h3C02;
`else
    tie_exp = 16'h3C01;
`endif
    #2;
    check("reset outputs", {13'd0, busy, done, err, read_mem, write_mem, data_address, data_in}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("one_plus_one", 16'h3C00, 16'h3C00, 16'h4000, 8, 1'b0);
    run_op("k1",           16'h3C00, 16'h4000, 16'h4200, 9, 1'b0);
    run_op("tie_k11",      16'h3C01, 16'h1000, tie_exp, 19, 1'b0);
    run_op("overflow_inf", 16'h7BFF, 16'h7BFF, 16'h7C00, 8, 1'b0);
    run_op("nil_k12",      16'h0000, 16'h4500, 16'h4500, 20, 1'b0);
    run_op("sign_mis",     16'h3C00, 16'hBC00, 16'h0000, 6, 1'b1);
    run_op("after_err",    16'h4500, 16'h3C00, 16'h4600, 10, 1'b0);

    // Abort during ALIGN: outputs drop at once and the destination stays untouched.
    preload(16'h0000, 16'h4500);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("abort outputs", {13'd0, busy, done, err, read_mem, write_mem, data_address, data_in}, 32'd0);
    repeat (3) @(posedge clk);
    #1 check("abort no write", {16'd0, mem[132], mem[133]}, 32'h0000EEEE);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("post_reset",   16'h4000, 16'h3C00, 16'h4200, 9, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fltadd_seq.md
# fltadd_seq

Multi-cycle sequencer for half-precision-style float addition: sign[7], exp[6:2] (5 bits, bias 15), mantissa 10 bits as {byte0[1:0], byte1}.
- On `start` it fetches two operands from data memory over the single-port DataMem interface.
- It aligns the smaller operand one bit per cycle, adds, normalizes, rounds, and writes the sum back to memory.
- It is the hardware controller that replaces the behavioral float-add program; it owns the data-memory port while busy.

## Interface
- `SRC_ADDR`, default 128: address of operand A byte0; A byte1 is at +1; B byte0/byte1 are at +2/+3.
- `DST_ADDR`, default 132: address of result byte0; result byte1 is at +1.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low; all state clears immediately while low.
- `start` in 1: request; sampled only in IDLE/DONE.
- `busy` out 1: high from the first load cycle through the last write cycle.
- `done` out 1: result written; held high until the next accepted `start` or reset.
- `err` out 1: operand signs differed; valid while `done`=1.
- `DataAddress` out 8: memory address.
- `ReadMem` out 1: read strobe.
- `WriteMem` out 1: write strobe; memory writes on the clock edge.
- `DataIn` out 8: write data to memory.
- `DataOut` in 8: read data from memory; combinational, valid in the same cycle the address is driven.

## Operation
- FSM states: IDLE → LD0 → LD1 → LD2 → LD3 → ALIGN → ADD → RND → WR0 → WR1 → DONE. DONE returns to LD0 on `start`.
- LDn: drive `DataAddress`=SRC_ADDR+n with `ReadMem`=1; capture `DataOut` at the end of the cycle.
- Decode: nil = (exp==0). A nil operand has hidden bit 0 and is treated as zero; no denormal arithmetic. Otherwise the hidden bit is 1, giving an 11-bit significand.
- ALIGN:
  - Load counter k = min(|expA−expB|, 12).
  - Each cycle, shift the smaller-exponent significand right by one: sticky |= round; round = lsb.
  - The state is skipped entirely when k=0. Result exponent = larger exponent.
- ADD: 12-bit sum. If sum[11]=1: shift right by one (sticky |= round, round = lsb) and increment the exponent.
- RND: rounding per Configuration.
  - A rounding carry into bit 11 → shift right by one, exponent+1.
  - Exponent ≥31 → force exp=31, mant=0 (infinity). Sum significand of 0 → result 0x0000.
- Sign mismatch (signA≠signB): skip ALIGN/ADD/RND; write 0x00,0x00; set `err`. Otherwise sign = signA and `err`=0.
- WR0/WR1: `WriteMem`=1, `DataAddress`=DST_ADDR / DST_ADDR+1, `DataIn`={sign,exp,mant[9:8]} / mant[7:0].
- `start` while busy is ignored. `start` held high in DONE restarts the operation immediately.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `ReadMem`=0, `WriteMem`=0, `DataAddress`=0, `DataIn`=0; state is IDLE; all datapath registers are 0.
- Latency: `start` sampled at edge 0 → `done` rises k+8 cycles later. Breakdown: 4 loads, k align, ADD, RND, 2 writes.
- Sign mismatch: `done` rises 6 cycles after `start` is sampled.
- `busy` and `done` are never high together. Strobes are only asserted in LD*/WR* states.
- Reset asserted mid-operation: abort immediately with no further writes. A write already committed in WR0 remains in memory.

## Configuration
- `FLTADD_RNE_EN` defined: round-to-nearest-even. Increment when round=1 and (sticky=1 or mant lsb=1).
- Undefined: truncate. round and sticky are still tracked but ignored; no increment is ever applied.

## Test plan
- 0x3C00 + 0x3C00 (1.0+1.0) → mem[132..133] = 0x40,0x00; `done` 8 cycles after `start`; `err`=0.
- 0x3C00 + 0x4000 (k=1) → 0x42,0x00; `done` 9 cycles after `start`; verify `busy` covers cycles 1–8.
- 0x3C01 + 0x1000 (tie, k=11) → with `FLTADD_RNE_EN` 0x3C02, without it 0x3C01; `done` after 19 cycles.
- 0x7BFF + 0x7BFF → 0x7C00 (infinity). 0x0000 + 0x4500 → 0x4500 with k=12, `done` after 20 cycles.
- 0x3C00 + 0xBC00 → 0x00,0x00, `err`=1, `done` after 6 cycles. Next `start` with valid operands clears `err`.
- Pull `reset` low during ALIGN → all outputs 0 asynchronously, no writes to 132/133. A fresh `start` then completes normally.
